// File: rtl/sys_defs.sv
// -----------------------------------------------------------------------------
// sys_defs
// Shared front-end type and constant definitions.
//   INST       : one RV32 instruction word.
//   FQ_PACKET  : one fetch queue entry (instruction, PC, predecode flags).
//   FQ_DEPTH   : fetch queue depth used by the fetch/dispatch top level.
// -----------------------------------------------------------------------------
package sys_defs;

    typedef logic [31:0] INST;

    typedef struct packed {
        INST         inst;
        logic [31:0] pc;
        logic        cond_branch;
        logic        uncond_branch;
        logic        jump;
        logic        link;
    } FQ_PACKET;

    localparam int FQ_DEPTH = 8;

endpackage : sys_defs

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Circular-buffer instruction queue between predecode and decode/dispatch.
// One enqueue and one dequeue per cycle, valid/ready on both sides, flush
// empties the queue on the next edge.
//
// Ports
//   clock             in   sole clock, rising edge
//   reset_n           in   asynchronous active-low reset
//   flush             in   squash all entries; overrides enqueue/dequeue
//   enq_valid         in   fetch presents an entry
//   enq_inst          in   instruction word
//   enq_pc            in   instruction PC
//   enq_cond_branch   in   predecode flag
//   enq_uncond_branch in   predecode flag
//   enq_jump          in   predecode flag
//   enq_link          in   predecode flag
//   enq_ready         out  queue can accept an entry (count < DEPTH)
//   deq_valid         out  head entry is valid (count != 0)
//   deq_ready         in   dispatch takes the head entry
//   deq_packet        out  head entry, all zero when deq_valid is low
//   count             out  number of occupied entries
// -----------------------------------------------------------------------------
module fetch_queue
    import sys_defs::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  INST                      enq_inst,
    input  logic [31:0]              enq_pc,
    input  logic                     enq_cond_branch,
    input  logic                     enq_uncond_branch,
    input  logic                     enq_jump,
    input  logic                     enq_link,
    output logic                     enq_ready,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output FQ_PACKET                 deq_packet,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    FQ_PACKET mem [DEPTH];
    FQ_PACKET enq_packet;

    logic enq_fire;
    logic deq_fire;

    // Status comes from registered count only, so enq_ready never sees
    // deq_ready: a full queue refuses an entry even while it is draining.
    assign enq_ready = (count_reg < DEPTH_CNT);
    assign deq_valid = (count_reg != '0);
    assign count     = count_reg;

    assign enq_fire = enq_valid && enq_ready && !flush;
    assign deq_fire = deq_valid && deq_ready && !flush;

    always_comb begin
        enq_packet               = '0;
        enq_packet.inst          = enq_inst;
        enq_packet.pc            = enq_pc;
        enq_packet.cond_branch   = enq_cond_branch;
        enq_packet.uncond_branch = enq_uncond_branch;
        enq_packet.jump          = enq_jump;
        enq_packet.link          = enq_link;
    end

    always_comb begin
        count_next = count_reg;
        case ({enq_fire, deq_fire})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointers are exactly log2(DEPTH) bits wide, so +1 wraps on its own.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head      <= '0;
            tail      <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            count_reg <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + PTR_W'(1);
            end
            if (deq_fire) begin
                head <= head + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // Entry storage is never reset or cleared; stale data is hidden by
    // the deq_valid mask on the read side.
    always_ff @(posedge clock) begin
        if (enq_fire) begin
            mem[tail] <= enq_packet;
        end
    end

    always_comb begin
        deq_packet = '0;
        if (deq_valid) begin
            deq_packet = mem[head];
        end
    end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import sys_defs::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clock;
    logic            reset_n;
    logic            flush;
    logic            enq_valid;
    INST             enq_inst;
    logic [31:0]     enq_pc;
    logic            enq_cond_branch;
    logic            enq_uncond_branch;
    logic            enq_jump;
    logic            enq_link;
    logic            enq_ready;
    logic            deq_valid;
    logic            deq_ready;
    FQ_PACKET        deq_packet;
    logic [CW-1:0]   count;

    int checks   = 0;
    int failures = 0;

    FQ_PACKET mq[$];   // reference queue: front is the head entry

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .flush             (flush),
        .enq_valid         (enq_valid),
        .enq_inst          (enq_inst),
        .enq_pc            (enq_pc),
        .enq_cond_branch   (enq_cond_branch),
        .enq_uncond_branch (enq_uncond_branch),
        .enq_jump          (enq_jump),
        .enq_link          (enq_link),
        .enq_ready         (enq_ready),
        .deq_valid         (deq_valid),
        .deq_ready         (deq_ready),
        .deq_packet        (deq_packet),
        .count             (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the reference queue.
    task automatic check_all(input string tag);
        FQ_PACKET exp_pkt;
        logic [CW-1:0] exp_cnt;
        exp_pkt = (mq.size() != 0) ? mq[0] : '0;
        exp_cnt = CW'(mq.size());
        chk1({tag, ".enq_ready"}, enq_ready, mq.size() < DEPTH);
        chk1({tag, ".deq_valid"}, deq_valid, mq.size() != 0);
        chk32({tag, ".count"}, 32'(count), 32'(exp_cnt));
        checks++;
        assert (deq_packet === exp_pkt) else begin
            failures++;
            $error("FAIL %s.deq_packet observed=%h expected=%h", tag, deq_packet, exp_pkt);
        end
    endtask

    task automatic set_enq(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                           input logic [3:0] flags);
        enq_valid         = v;
        enq_pc            = pc;
        enq_inst          = inst;
        enq_cond_branch   = flags[3];
        enq_uncond_branch = flags[2];
        enq_jump          = flags[1];
        enq_link          = flags[0];
    endtask

    // Apply current inputs for one clock edge, update the model, check.
    task automatic cycle(input string tag);
        FQ_PACKET pin;
        bit ef, df;
        pin = '{inst: enq_inst, pc: enq_pc, cond_branch: enq_cond_branch,
                uncond_branch: enq_uncond_branch, jump: enq_jump, link: enq_link};
        ef = enq_valid && (mq.size() < DEPTH) && !flush;
        df = deq_ready && (mq.size() != 0) && !flush;
        @(posedge clock);
        if (flush) begin
            mq.delete();
        end else begin
            if (df) mq.delete(0);
            if (ef) mq.push_back(pin);
        end
        @(negedge clock);
        check_all(tag);
        $display("cyc %s enq_v=%0b deq_r=%0b flush=%0b count=%0d deq_v=%0b pc=%h",
                 tag, enq_valid, deq_ready, flush, count, deq_valid, deq_packet.pc);
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        deq_ready = 1'b0;
        set_enq(1'b0, 32'h0, 32'h0, 4'b0000);
        #12;
        check_all("reset");
        chk1("reset.enq_ready", enq_ready, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;

        // Three in-order entries, then drain.
        for (int i = 0; i < 3; i++) begin
            set_enq(1'b1, 32'h100 + 32'(4 * i), 32'h13 + 32'(i), 4'b0000);
            cycle("fill3");
        end
        set_enq(1'b0, 32'h0, 32'h0, 4'b0000);
        chk32("fill3.count", 32'(count), 32'd3);
        deq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk32("drain3.pc", deq_packet.pc, 32'h100 + 32'(4 * i));
            cycle("drain3");
        end
        chk1("drain3.empty", deq_valid, 1'b0);
        deq_ready = 1'b0;

        // Full boundary.
        for (int i = 0; i < 4; i++) begin
            set_enq(1'b1, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 4'b0000);
            cycle("full");
        end
        chk1("full.enq_ready", enq_ready, 1'b0);
        chk32("full.count", 32'(count), 32'd4);
        set_enq(1'b1, 32'h200, 32'hBEEF, 4'b0000);
        cycle("full.reject");
        chk32("full.reject.count", 32'(count), 32'd4);
        deq_ready = 1'b1;
        cycle("full.deq_with_enq");
        chk32("full.deq.count", 32'(count), 32'd3);
        chk1("full.deq.enq_ready", enq_ready, 1'b1);
        deq_ready = 1'b0;
        cycle("full.accept200");
        set_enq(1'b0, 32'h0, 32'h0, 4'b0000);
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk32("full.order.pc", deq_packet.pc, (i == 3) ? 32'h200 : 32'h14 + 32'(4 * i));
            cycle("full.drain");
        end
        deq_ready = 1'b0;

        // Steady-state enqueue+dequeue across pointer wrap.
        for (int i = 0; i < 2; i++) begin
            set_enq(1'b1, 32'h300 + 32'(4 * i), 32'h0, 4'b0000);
            cycle("wrap.prefill");
        end
        deq_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk32("wrap.pc", deq_packet.pc, 32'h300 + 32'(4 * i));
            set_enq(1'b1, 32'h308 + 32'(4 * i), 32'h0, 4'b0000);
            cycle("wrap");
            chk32("wrap.count", 32'(count), 32'd2);
        end
        set_enq(1'b0, 32'h0, 32'h0, 4'b0000);
        cycle("wrap.drain");
        cycle("wrap.drain");
        deq_ready = 1'b0;

        // Predecode flags pass through untouched.
        set_enq(1'b1, 32'h40, 32'h0080006F, 4'b0110);   // JAL
        cycle("flags.jal");
        set_enq(1'b1, 32'h44, 32'h000080E7, 4'b0101);   // JALR
        cycle("flags.jalr");
        set_enq(1'b0, 32'h0, 32'h0, 4'b0000);
        deq_ready = 1'b1;
        chk32("flags.jal.flags", 32'({deq_packet.cond_branch, deq_packet.uncond_branch,
              deq_packet.jump, deq_packet.link}), 32'b0110);
        cycle("flags.deq1");
        chk32("flags.jalr.flags", 32'({deq_packet.cond_branch, deq_packet.uncond_branch,
              deq_packet.jump, deq_packet.link}), 32'b0101);
        cycle("flags.deq2");
        deq_ready = 1'b0;

        // Flush wins over a simultaneous enqueue and dequeue.
        for (int i = 0; i < 3; i++) begin
            set_enq(1'b1, 32'h500 + 32'(4 * i), 32'h0, 4'b1000);
            cycle("flush.fill");
        end
        set_enq(1'b1, 32'h5FC, 32'h0, 4'b0000);
        deq_ready = 1'b1;
        flush     = 1'b1;
        cycle("flush");
        flush = 1'b0;
        set_enq(1'b0, 32'h0, 32'h0, 4'b0000);
        chk32("flush.count", 32'(count), 32'd0);
        chk1("flush.deq_valid", deq_valid, 1'b0);
        chk1("flush.enq_ready", enq_ready, 1'b1);
        cycle("flush.after");
        deq_ready = 1'b0;

        // Asynchronous reset in mid-cycle.
        for (int i = 0; i < 3; i++) begin
            set_enq(1'b1, 32'h700 + 32'(4 * i), 32'h0, 4'b0000);
            cycle("arst.fill");
        end
        set_enq(1'b0, 32'h0, 32'h0, 4'b0000);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        mq.delete();
        #1;
        chk1("arst.deq_valid", deq_valid, 1'b0);
        chk32("arst.count", 32'(count), 32'd0);
        chk1("arst.enq_ready", enq_ready, 1'b1);
        check_all("arst");
        @(negedge clock);
        reset_n = 1'b1;
        cycle("arst.after");

        // Randomized traffic against the reference queue.
        for (int i = 0; i < 400; i++) begin
            set_enq(($urandom_range(0, 3) != 0), $urandom, $urandom, 4'($urandom));
            deq_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            cycle("rand");
        end
        flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_queue

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the predecode stage and decode/dispatch. Each entry holds one fetched RV32 instruction with its PC and its four predecode flags (cond_branch, uncond_branch, jump, link). Fetch writes up to one entry per cycle and dispatch reads up to one per cycle over a valid/ready handshake. A flush from branch recovery empties the queue.

## Interface
- DEPTH, 8: number of entries; power of two, at least 2.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  squash all entries (mispredict or exception recovery).
- enq_valid  in  1  fetch presents an entry this cycle.
- enq_inst  in  32 (INST)  instruction word.
- enq_pc  in  32  instruction PC.
- enq_cond_branch, enq_uncond_branch, enq_jump, enq_link  in  1 each  predecode flags.
- enq_ready  out  1  queue can accept an entry this cycle.
- deq_valid  out  1  head entry is valid.
- deq_ready  in  1  dispatch takes the head entry this cycle.
- deq_packet  out  FQ_PACKET  head entry: inst, pc and the four flags.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage is a circular buffer of DEPTH FQ_PACKET entries, indexed by head and tail pointers of width $clog2(DEPTH). Pointers wrap naturally from DEPTH-1 to 0. The count register separates the full and empty states.
- enq_ready = (count < DEPTH). It is combinational from registered state only and never depends on deq_ready. There is no enqueue while full, even if a dequeue happens in the same cycle.
- Enqueue fires when enq_valid && enq_ready && !flush. The entry is written at tail, and tail advances by 1.
- deq_valid = (count != 0). deq_packet is read combinationally from the head entry. When deq_valid=0, all deq_packet fields are driven to 0.
- Dequeue fires when deq_valid && deq_ready && !flush. Head advances by 1.
- count_next = count + enq_fire - deq_fire. If both fire in the same cycle, count is unchanged and both pointers advance.
- There is no bypass. An entry enqueued in cycle N is visible at the head no earlier than cycle N+1. When the queue is empty, deq_ready is ignored.
- Flush is synchronous and has the highest priority:
  - On the next edge, head, tail and count go to 0.
  - Any enqueue or dequeue in the flush cycle is discarded. Dispatch must not treat a handshake in that cycle as consumed.
  - Entry contents are not cleared, and deq_valid masking hides them.
- Entry storage is not reset. Only the pointers and count are.
- Flag fields are stored exactly as presented. The queue does not interpret them.

## Timing
- Reset (reset_n low, asynchronous): head=0, tail=0, count=0. Outputs: deq_valid=0, deq_packet=0, enq_ready=1, count=0.
- Reset deasserted mid-operation: the queue is empty; prior contents are lost.
- Enqueue-to-dequeue latency: 1 cycle minimum.
- Throughput: 1 enqueue plus 1 dequeue per cycle in steady state, whenever 0 < count < DEPTH.
- Full (count=DEPTH): enq_ready=0. A dequeue that cycle drops count to DEPTH-1, and enq_ready=1 in the next cycle.
- Empty (count=0): deq_valid=0. An enqueue that cycle sets deq_valid=1 in the next cycle.
- Flush with reset_n high: enq_ready=1 and deq_valid=0 in the cycle after flush.

## Structure
- Shared package sys_defs holds:
  - typedef FQ_PACKET: INST inst, [31:0] pc, and 1-bit cond_branch, uncond_branch, jump, link.
  - constant FQ_DEPTH (default 8), which the fetch/dispatch top level passes as DEPTH.
- One module with inline storage; no sub-module is needed.
- head, tail and count live in one always_ff with asynchronous negedge reset_n. The storage array lives in a separate always_ff with no reset.

## Test plan
- Reset, then enqueue PCs 0x100, 0x104, 0x108 on consecutive cycles with deq_ready=0 -> count=3. Then raise deq_ready -> deq_packet.pc is 0x100, 0x104, 0x108 in order, and deq_valid falls after the third.
- DEPTH=4: enqueue 4 entries with deq_ready=0 -> enq_ready=0 and count=4. A 5th enq_valid (pc 0x200) is not accepted. Dequeue one -> enq_ready=1 next cycle, and 0x200 lands 4th in order.
- Simultaneous enqueue and dequeue for 20 cycles starting at count=2 with DEPTH=4 -> count stays 2, pointers wrap, and FIFO order is preserved across the wrap.
- Enqueue JAL at pc 0x40 with uncond_branch=1, jump=1 and JALR at 0x44 with uncond_branch=1, link=1 -> the dequeued flags match exactly, and the other flags are 0.
- Fill 3 entries, then assert flush together with enq_valid and deq_ready -> next cycle count=0, deq_valid=0, and the flush-cycle enqueue is absent.
- Assert reset_n low asynchronously mid-cycle with count=3 -> deq_valid=0, count=0, enq_ready=1 immediately, without waiting for a clock edge.
